// File: rtl/pc_pipe.sv
// pc_pipe: fetch PC generator plus per-stage PC/valid tracker for the in-order
// pipeline. Supports stall (front-end hold with bubble insertion), redirect
// (new fetch target with wrong-path squash), a misaligned-target pulse and a
// retired-instruction counter. All outputs come directly from registers.
module pc_pipe #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR   = XLEN'(32'h0100_0000),
  parameter int unsigned     STAGES         = 5,
  parameter int unsigned     STALL_DEPTH    = 2,
  parameter int unsigned     REDIRECT_STAGE = 2,
  parameter int unsigned     INC            = 4,
  parameter int unsigned     CNT_W          = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_target_i,
  output logic [STAGES*XLEN-1:0]   pc_o,
  output logic [STAGES-1:0]        valid_o,
  output logic [XLEN-1:0]          fetch_pc_o,
  output logic                     misaligned_o,
  output logic [CNT_W-1:0]         retired_o
);

  logic [XLEN-1:0]   pc_q [STAGES];
  logic [XLEN-1:0]   pc_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Next stage state: start from a plain shift, then overlay redirect squash
  // or stall hold. Redirect wins over stall, so the front end is never held
  // in a redirect cycle.
  always_comb begin
    valid_d   = valid_q;
    pc_d[0]   = pc_q[0] + XLEN'(INC);
    valid_d[0] = 1'b1;
    for (int unsigned k = 1; k < STAGES; k++) begin
      pc_d[k]    = pc_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
    if (redirect_i) begin
      pc_d[0] = redirect_target_i;
      for (int unsigned k = 1; k <= REDIRECT_STAGE; k++) begin
        valid_d[k] = 1'b0;
      end
    end else if (stall_i) begin
      for (int unsigned k = 0; k < STALL_DEPTH; k++) begin
        pc_d[k]    = pc_q[k];
        valid_d[k] = valid_q[k];
      end
      valid_d[STALL_DEPTH] = 1'b0;
    end
  end

  // Stage registers, misaligned pulse and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        pc_q[k] <= RESET_VECTOR;
      end
      valid_q      <= STAGES'(1);
      misaligned_o <= 1'b0;
      retired_o    <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        pc_q[k] <= pc_d[k];
      end
      valid_q      <= valid_d;
      misaligned_o <= redirect_i & (|redirect_target_i[1:0]);
      retired_o    <= retired_o + CNT_W'(valid_q[STAGES-1]);
    end
  end

  // Flatten the stage PCs onto the output bus.
  always_comb begin
    pc_o = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      pc_o[k*XLEN +: XLEN] = pc_q[k];
    end
  end

  assign valid_o    = valid_q;
  assign fetch_pc_o = pc_q[0];

endmodule

// File: tb/tb_pc_pipe.sv
// Testbench for pc_pipe with default parameters: a table of stimulus rows
// with hand-derived expected state, pushed onto a scoreboard queue when
// driven and popped/compared one edge later.
module tb_pc_pipe;

  localparam logic [31:0] RV = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic [159:0] pc_o;
  logic [4:0]  valid_o;
  logic [31:0] fetch_pc_o;
  logic        misaligned_o;
  logic [31:0] retired_o;

  pc_pipe #(
    .XLEN(32), .RESET_VECTOR(RV), .STAGES(5), .STALL_DEPTH(2),
    .REDIRECT_STAGE(2), .INC(4), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .pc_o(pc_o), .valid_o(valid_o),
    .fetch_pc_o(fetch_pc_o), .misaligned_o(misaligned_o), .retired_o(retired_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] tgt;
    logic [31:0] f, d, s3, s4;
    logic [4:0]  v;
    logic        m;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic row(input logic rst, input logic stl, input logic rdr,
                     input logic [31:0] tgt, input logic [31:0] f,
                     input logic [31:0] d, input logic [31:0] s3,
                     input logic [31:0] s4, input logic [4:0] v,
                     input logic m, input logic [31:0] r);
    vec_t x;
    x.rst = rst; x.stl = stl; x.rdr = rdr; x.tgt = tgt;
    x.f = f; x.d = d; x.s3 = s3; x.s4 = s4; x.v = v; x.m = m; x.r = r;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input int idx);
    vec_t e;
    reset = x.rst; stall_i = x.stl; redirect_i = x.rdr; redirect_target_i = x.tgt;
    exp_q.push_back(x);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("fetch_pc", idx, fetch_pc_o, e.f);
    check("pc0", idx, pc_o[0 +: 32], e.f);
    check("pc1", idx, pc_o[32 +: 32], e.d);
    check("pc3", idx, pc_o[96 +: 32], e.s3);
    check("pc4", idx, pc_o[128 +: 32], e.s4);
    check("valid", idx, {27'd0, valid_o}, {27'd0, e.v});
    check("misaligned", idx, {31'd0, misaligned_o}, {31'd0, e.m});
    check("retired", idx, retired_o, e.r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then 6 free-running cycles.
    row(1, 0, 0, 0, RV, RV, RV, RV, 5'b00001, 0, 0);
    row(0, 0, 0, 0, RV+4,  RV,    RV,   RV,   5'b00011, 0, 0);
    row(0, 0, 0, 0, RV+8,  RV+4,  RV,   RV,   5'b00111, 0, 0);
    row(0, 0, 0, 0, RV+12, RV+8,  RV,   RV,   5'b01111, 0, 0);
    row(0, 0, 0, 0, RV+16, RV+12, RV+4, RV,   5'b11111, 0, 0);
    row(0, 0, 0, 0, RV+20, RV+16, RV+8, RV+4, 5'b11111, 0, 1);
    row(0, 0, 0, 0, RV+24, RV+20, RV+12, RV+8, 5'b11111, 0, 2);
    // Reset, 4 free cycles, 2-cycle stall at fetch 0x01000010, 4 free cycles.
    row(1, 0, 0, 0, RV, RV, RV, RV, 5'b00001, 0, 0);
    row(0, 0, 0, 0, RV+4,  RV,    RV,   RV,   5'b00011, 0, 0);
    row(0, 0, 0, 0, RV+8,  RV+4,  RV,   RV,   5'b00111, 0, 0);
    row(0, 0, 0, 0, RV+12, RV+8,  RV,   RV,   5'b01111, 0, 0);
    row(0, 0, 0, 0, RV+16, RV+12, RV+4, RV,   5'b11111, 0, 0);
    row(0, 1, 0, 0, RV+16, RV+12, RV+8,  RV+4,  5'b11011, 0, 1);
    row(0, 1, 0, 0, RV+16, RV+12, RV+12, RV+8,  5'b10011, 0, 2);
    row(0, 0, 0, 0, RV+20, RV+16, RV+12, RV+12, 5'b00111, 0, 3);
    row(0, 0, 0, 0, RV+24, RV+20, RV+12, RV+12, 5'b01111, 0, 3);
    row(0, 0, 0, 0, RV+28, RV+24, RV+16, RV+12, 5'b11111, 0, 3);
    row(0, 0, 0, 0, RV+32, RV+28, RV+20, RV+16, 5'b11111, 0, 4);
    // Reset, 4 free cycles, redirect to 0x01000100 while E holds 0x01000008.
    row(1, 0, 0, 0, RV, RV, RV, RV, 5'b00001, 0, 0);
    row(0, 0, 0, 0, RV+4,  RV,    RV,   RV,   5'b00011, 0, 0);
    row(0, 0, 0, 0, RV+8,  RV+4,  RV,   RV,   5'b00111, 0, 0);
    row(0, 0, 0, 0, RV+12, RV+8,  RV,   RV,   5'b01111, 0, 0);
    row(0, 0, 0, 0, RV+16, RV+12, RV+4, RV,   5'b11111, 0, 0);
    row(0, 0, 1, RV+32'h100, RV+32'h100, RV+16, RV+8, RV+4, 5'b11001, 0, 1);
    row(0, 0, 0, 0, RV+32'h104, RV+32'h100, RV+12, RV+8, 5'b10011, 0, 2);
    row(0, 0, 0, 0, RV+32'h108, RV+32'h104, RV+16, RV+12, 5'b00111, 0, 3);
    row(0, 0, 0, 0, RV+32'h10C, RV+32'h108, RV+32'h100, RV+16, 5'b01111, 0, 3);
    row(0, 0, 0, 0, RV+32'h110, RV+32'h10C, RV+32'h104, RV+32'h100, 5'b11111, 0, 3);
    row(0, 0, 0, 0, RV+32'h114, RV+32'h110, RV+32'h108, RV+32'h104, 5'b11111, 0, 4);
    // Misaligned redirect with stall in the same cycle, then a free cycle.
    row(0, 1, 1, RV+32'h102, RV+32'h102, RV+32'h114, RV+32'h10C, RV+32'h108, 5'b11001, 1, 5);
    row(0, 0, 0, 0, RV+32'h106, RV+32'h102, RV+32'h110, RV+32'h10C, 5'b10011, 0, 6);
    // Wrap of the fetch PC past 2^32.
    row(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, RV+32'h106, RV+32'h114, RV+32'h110, 5'b00001, 0, 7);
    row(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, RV+32'h102, RV+32'h114, 5'b00011, 0, 7);
    row(0, 0, 0, 0, 32'h4, 32'h0, RV+32'h106, RV+32'h102, 5'b00111, 0, 7);
    // Misaligned redirect, then reset together with stall and redirect.
    row(0, 0, 1, RV+32'h103, RV+32'h103, 32'h4, 32'hFFFF_FFFC, RV+32'h106, 5'b01001, 1, 7);
    row(1, 1, 1, RV+32'h103, RV, RV, RV, RV, 5'b00001, 0, 0);
    row(0, 0, 0, 0, RV+4, RV, RV, RV, 5'b00011, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Back-to-back redirects: each is taken, the later target wins.
    begin
      vec_t x;
      x.rst = 0; x.stl = 0; x.rdr = 1; x.tgt = 32'h300;
      x.f = 32'h300; x.d = RV+4; x.s3 = RV; x.s4 = RV; x.v = 5'b00001; x.m = 0; x.r = 0;
      apply(x, 100);
      x.tgt = 32'h400; x.f = 32'h400; x.d = 32'h300;
      apply(x, 101);
      x.rdr = 0; x.tgt = 0; x.f = 32'h404; x.d = 32'h400; x.s3 = RV+4; x.v = 5'b00011;
      apply(x, 102);
    end

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_pipe.md
# pc_pipe

Parametrised program-counter generator and per-stage PC/valid tracker for the in-order RISC-V pipeline. It produces the fetch PC and carries each in-flight instruction's PC and valid bit down a configurable number of stages. It supports stall (hold the front end, inject a bubble), redirect (load a branch/jump target and squash wrong-path stages), a misaligned-target flag and a retired-instruction counter. It sits at the front of the datapath, feeds the instruction memory address, and supplies PCs to decode, execute, memory and writeback.

## Interface
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 32'h01000000: PC loaded into stage 0 on reset.
- STAGES, 5: number of tracked stages (0 = F … STAGES-1 = W). Range 3..8.
- STALL_DEPTH, 2: stages 0..STALL_DEPTH-1 hold on stall. Range 1..STAGES-1.
- REDIRECT_STAGE, 2: stage that resolves redirects (E). Range 1..STAGES-2.
- INC, 4: sequential PC increment.
- CNT_W, 32: retire counter width.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  hold front-end stages this cycle.
- redirect_i  in  1  load redirect_target_i as the next fetch PC; squash younger stages.
- redirect_target_i  in  XLEN  redirect target, sampled when redirect_i=1.
- pc_o  out  STAGES*XLEN  flattened stage PCs; stage k at bits [k*XLEN +: XLEN].
- valid_o  out  STAGES  per-stage valid bits.
- fetch_pc_o  out  XLEN  equals stage 0 PC.
- misaligned_o  out  1  one-cycle pulse: the previous accepted redirect target had bits [1:0] != 0.
- retired_o  out  CNT_W  count of cycles with valid_o[STAGES-1]=1.

## Operation
- Reset (clock edge with reset=1):
  - every pc[k] = RESET_VECTOR.
  - valid = {0…0,1}: only stage 0 is valid.
  - misaligned_o = 0, retired_o = 0.
  - Reset overrides all other inputs, including mid-redirect and mid-stall.
- Priority each cycle: reset > redirect_i > stall_i > normal advance.
- Normal advance:
  - pc[0] <= pc[0] + INC, arithmetic modulo 2^XLEN (wrap to 0, no flag); valid[0] <= 1.
  - pc[k] <= pc[k-1] and valid[k] <= valid[k-1] for k >= 1.
- Stall (redirect_i=0):
  - stages 0..STALL_DEPTH-1 hold PC and valid.
  - stage STALL_DEPTH gets pc[STALL_DEPTH-1] with valid = 0 (bubble).
  - stages above STALL_DEPTH shift normally.
- Redirect (stall_i ignored):
  - pc[0] <= redirect_target_i; valid[0] <= 1.
  - stages 1..REDIRECT_STAGE take the shifted PC with valid = 0 (wrong-path squash).
  - stages above REDIRECT_STAGE shift normally, so the redirecting instruction continues to retire.
- The target is used unmodified. misaligned_o <= |redirect_target_i[1:0] on a redirect cycle, otherwise 0.
- Retire counter: retired_o increments when valid[STAGES-1]=1 at the edge, and wraps modulo 2^CNT_W.
- The block performs no combinational path from inputs to outputs.

## Timing
- All outputs are registered and change only on the rising clock edge.
- Redirect latency is 1 cycle: a target presented in cycle n appears on fetch_pc_o in cycle n+1.
- A fetched instruction reaches stage k k cycles after fetch when there are no stalls.
- Each stall cycle adds 1 cycle of delay to the held stages and 1 bubble.
- Back-to-back redirects are each taken; the later target wins in the cycle after it.
- Redirect and stall in the same cycle behave as a redirect, and the front end is not held.
- misaligned_o is high for exactly the cycle after a misaligned redirect.
- retired_o reflects retirements up to and including the previous edge.

## Test plan
- Reset then 6 free cycles, defaults:
  - fetch_pc_o steps 0x01000000, 0x01000004, … 0x01000018.
  - valid_o fills 00001→00011→…→11111.
  - stage 4 PC is 0x01000000 when valid_o[4] first rises.
  - retired_o = 1 one cycle later.
- Stall held 2 cycles at fetch_pc_o=0x01000010:
  - F holds 0x01000010 and D holds 0x0100000C.
  - Stage 2 shows valid=0 for 2 consecutive cycles.
  - Stages 3–4 keep shifting.
  - Retire count lags the no-stall run by 2.
- Redirect to 0x01000100 while E holds 0x01000008:
  - Next cycle fetch_pc_o = 0x01000100; valid_o[1]=valid_o[2]=0; stage 3 = 0x01000008 valid.
  - misaligned_o = 0.
  - Squashed PCs never increment retired_o.
- Redirect to 0x01000102 with stall_i=1 in the same cycle:
  - Redirect is taken and fetch_pc_o = 0x01000102.
  - misaligned_o pulses 1 for one cycle.
- Wrap: redirect to 0xFFFFFFFC:
  - fetch_pc_o goes 0xFFFFFFFC, then 0x00000000, then 0x00000004.
- Reset asserted during a stall and a redirect:
  - Next cycle all PCs = 0x01000000, valid_o = 00001, retired_o = 0, misaligned_o = 0.
